// File: rtl/dcache_wt.sv
// dcache_wt: set-associative write-through, no-write-allocate data cache.
// One request at a time; the core stalls through tag lookup, fill and write-through.
module dcache_wt #(
    parameter int ADDR_W = 32,
    parameter int LINES  = 64,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [3:0]        sign_mask,
    output logic [31:0]       read_data,
    output logic              clk_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        led,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, TAG, FILL, WRITE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata, r_hits, r_misses;
    logic [3:0]        r_mask;
    logic              r_write;
    logic [LINES-1:0]  r_valid [WAYS];
    logic [LINES-1:0]  r_lru;
    logic [TAG_W-1:0]  r_tag   [WAYS][LINES];
    logic [31:0]       r_data  [WAYS][LINES];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WAYS-1:0]   w_hitv;
    logic [31:0]       w_hitdata, w_wshift;
    logic [3:0]        w_strb;
    logic              w_hit, w_hitway, w_vict, w_byte, w_half, w_rd_hit, w_fill_done;

    function automatic logic [31:0] f_ext(input logic [31:0] w, input logic [3:0] m, input logic [1:0] a);
        logic [31:0] b, h;
        b = w >> {a, 3'b000};
        h = a[1] ? {16'b0, w[31:16]} : w;
        return (m[2:0] == 3'b001) ? {{24{m[3] & b[7]}}, b[7:0]} :
               (m[2:0] == 3'b011) ? {{16{m[3] & h[15]}}, h[15:0]} : w;
    endfunction

    assign w_idx    = r_addr[IDX_W+1:2];
    assign w_tag    = r_addr[ADDR_W-1:IDX_W+2];
    assign w_byte   = r_mask[2:0] == 3'b001;
    assign w_half   = r_mask[2:0] == 3'b011;
    assign w_strb   = w_byte ? 4'b0001 << r_addr[1:0] : w_half ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wshift = w_byte ? {24'b0, r_wdata[7:0]} << {r_addr[1:0], 3'b000} :
                      w_half ? (r_addr[1] ? {r_wdata[15:0], 16'b0} : {16'b0, r_wdata[15:0]}) : r_wdata;

    always_comb begin
        w_hitv    = '0;
        w_hitdata = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hitv[w] = 1'b1;
                w_hitdata = r_data[w][w_idx];
            end
    end

    assign w_hit       = |w_hitv;
    assign w_hitway    = (WAYS == 2) && w_hitv[WAYS-1];
    // Invalid way first (way 0 before way 1), otherwise the LRU way.
    assign w_vict      = (WAYS == 2) && r_valid[0][w_idx] && (!r_valid[WAYS-1][w_idx] || r_lru[w_idx]);
    assign w_rd_hit    = r_state == TAG && !r_write && w_hit;
    assign w_fill_done = r_state == FILL && mem_ready;

    assign read_data  = w_rd_hit ? f_ext(w_hitdata, r_mask, r_addr[1:0]) :
                        w_fill_done ? f_ext(mem_rdata, r_mask, r_addr[1:0]) : r_rdata;
    assign mem_read   = r_state == FILL;
    assign mem_write  = r_state == WRITE;
    assign mem_addr   = (mem_read || mem_write) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_write ? w_wshift : '0;
    assign mem_wstrb  = mem_write ? w_strb : '0;
    assign led        = r_misses[7:0];
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    always_comb begin
        w_next    = r_state;
        clk_stall = 1'b1;
        case (r_state)
            IDLE: begin
                clk_stall = memread | memwrite;
                w_next    = (memread | memwrite) ? TAG : IDLE;
            end
            TAG: begin
                clk_stall = !w_rd_hit;
                w_next    = r_write ? WRITE : w_hit ? IDLE : FILL;
            end
            default: begin
                clk_stall = !mem_ready;
                w_next    = mem_ready ? IDLE : r_state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_mask   <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
            r_lru    <= '0;
            for (int w = 0; w < WAYS; w++)
                r_valid[w] <= '0;
        end else begin
            r_state <= w_next;
            r_rdata <= read_data;
            if (r_state == IDLE && (memread || memwrite)) begin
                r_addr  <= addr;
                r_wdata <= write_data;
                r_mask  <= sign_mask;
                r_write <= memwrite;
            end
            if (r_state == TAG) begin
                if (w_hit) begin
                    r_hits <= r_hits + 32'd1;
                    if (WAYS == 2)
                        r_lru[w_idx] <= !w_hitway;
                end else begin
                    r_misses <= r_misses + 32'd1;
                end
            end
            if (w_fill_done) begin
                for (int w = 0; w < WAYS; w++)
                    if (1'(w) == w_vict)
                        r_valid[w][w_idx] <= 1'b1;
                if (WAYS == 2)
                    r_lru[w_idx] <= !w_vict;
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by r_valid alone.
    always_ff @(posedge clk) begin
        if (w_fill_done)
            for (int w = 0; w < WAYS; w++)
                if (1'(w) == w_vict) begin
                    r_tag[w][w_idx]  <= w_tag;
                    r_data[w][w_idx] <= mem_rdata;
                end
        if (r_state == TAG && r_write)
            for (int w = 0; w < WAYS; w++)
                if (w_hitv[w])
                    for (int b = 0; b < 4; b++)
                        if (w_strb[b])
                            r_data[w][w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
    end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed checks of dcache_wt with a small backing-memory responder.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0, write_data = '0, mem_rdata = '0;
    logic        memwrite = 1'b0, memread = 1'b0, mem_ready = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data, mem_addr, mem_wdata, hit_count, miss_count;
    logic [3:0]  mem_wstrb;
    logic        clk_stall, mem_read, mem_write;
    logic [7:0]  led;

    logic [31:0] mem [1024];
    int          vecs = 0, errs = 0;
    logic [31:0] r_rd, r_maddr, r_mwd;
    logic [3:0]  r_strb;
    logic        r_sawrd, r_sawwr, r_stall0;
    int          r_cyc;

    dcache_wt #(.ADDR_W(32), .LINES(16), .WAYS(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .clk_stall(clk_stall), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .led(led), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Issues one request, answers mem_read/mem_write after lat waiting cycles.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m, input int lat);
        int  waited;
        bit  done;
        waited = 0;
        done = 1'b0;
        @(negedge clk);
        addr = a; write_data = wd; sign_mask = m; memwrite = wr; memread = !wr;
        #1 r_stall0 = clk_stall;
        r_sawrd = 1'b0; r_sawwr = 1'b0; r_maddr = '0; r_mwd = '0; r_strb = '0;
        @(posedge clk);
        #1 memread = 1'b0; memwrite = 1'b0; addr = '0; write_data = '0; sign_mask = '0;
        r_cyc = 1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                r_sawrd |= mem_read; r_sawwr |= mem_write;
                r_maddr = mem_addr; r_mwd = mem_wdata; r_strb = mem_wstrb;
                if (waited == lat) begin
                    mem_ready = 1'b1;
                    if (mem_read) mem_rdata = mem[mem_addr[11:2]];
                    else for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else waited++;
            end
            #1;
            if (!clk_stall) begin
                r_rd = read_data;
                done = 1'b1;
            end
            r_cyc++;
            @(posedge clk);
            #1 mem_ready = 1'b0; mem_rdata = '0;
        end
        if (!done) begin
            vecs++; errs++;
            $display("FAIL access_timeout addr=%h: clk_stall stuck high, required release within 50 cycles", a);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({read_data, clk_stall, mem_read, mem_write, mem_wstrb} !== '0) begin
            errs++; $display("FAIL reset_outputs: got rd=%h stall=%b mr=%b mw=%b strb=%b, required all 0", read_data, clk_stall, mem_read, mem_write, mem_wstrb);
        end
        vecs++;
        if ({mem_addr, mem_wdata} !== '0) begin
            errs++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        vecs++;
        if ({hit_count, miss_count, led} !== '0) begin
            errs++; $display("FAIL reset_counters: got hit=%0d miss=%0d led=%h, required 0", hit_count, miss_count, led);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_read;
        mem[32'h40 >> 2] = 32'hAAAAAAAA;
        access(1'b0, 32'h40, '0, 4'b0111, 3);
        vecs++;
        if (r_stall0 !== 1'b1) begin errs++; $display("FAIL idle_stall: got %b required 1", r_stall0); end
        vecs++;
        if ({r_sawrd, r_sawwr} !== 2'b10) begin errs++; $display("FAIL cold_fill_req: got rd=%b wr=%b required rd=1 wr=0", r_sawrd, r_sawwr); end
        vecs++;
        if (r_maddr !== 32'h40) begin errs++; $display("FAIL cold_mem_addr: got %h required 00000040", r_maddr); end
        vecs++;
        if (r_rd !== 32'hAAAAAAAA) begin errs++; $display("FAIL cold_data: got %h required aaaaaaaa", r_rd); end
        vecs++;
        if (r_cyc !== 6) begin errs++; $display("FAIL cold_latency: got %0d required 6", r_cyc); end
        vecs++;
        if (miss_count !== 32'd1 || led !== 8'd1) begin errs++; $display("FAIL cold_miss_count: got %0d led %0d required 1", miss_count, led); end
        access(1'b0, 32'h40, '0, 4'b0111, 0);
        vecs++;
        if (r_cyc !== 2 || r_sawrd !== 1'b0) begin errs++; $display("FAIL hit_latency: got cyc=%0d memread=%b required cyc=2 memread=0", r_cyc, r_sawrd); end
        vecs++;
        if (r_rd !== 32'hAAAAAAAA || hit_count !== 32'd1) begin errs++; $display("FAIL hit_data: got %h hits=%0d required aaaaaaaa hits=1", r_rd, hit_count); end
    endtask

    task automatic test_byte;
        mem[32'h400 >> 2] = 32'h0;
        access(1'b0, 32'h400, '0, 4'b0111, 1);
        vecs++;
        if (r_rd !== 32'h0 || r_sawrd !== 1'b1) begin errs++; $display("FAIL byte_fill: got %h memread=%b required 0 memread=1", r_rd, r_sawrd); end
        access(1'b1, 32'h400, 32'hAAA, 4'b0001, 1);
        vecs++;
        if ({r_sawrd, r_sawwr, r_strb} !== 6'b01_0001) begin errs++; $display("FAIL byte_wstrb: got rd=%b wr=%b strb=%b required rd=0 wr=1 strb=0001", r_sawrd, r_sawwr, r_strb); end
        vecs++;
        if (r_mwd !== 32'h000000AA || r_maddr !== 32'h400) begin errs++; $display("FAIL byte_wdata: got %h @%h required 000000aa @00000400", r_mwd, r_maddr); end
        vecs++;
        if (r_rd !== 32'h0 || hit_count !== 32'd2) begin errs++; $display("FAIL byte_store_hold: got rd=%h hits=%0d required rd=0 hits=2", r_rd, hit_count); end
        access(1'b0, 32'h400, '0, 4'b1001, 0);
        vecs++;
        if (r_rd !== 32'hFFFFFFAA || r_cyc !== 2) begin errs++; $display("FAIL byte_signed: got %h cyc=%0d required ffffffaa cyc=2", r_rd, r_cyc); end
        access(1'b0, 32'h400, '0, 4'b0001, 0);
        vecs++;
        if (r_rd !== 32'h000000AA || r_cyc !== 2) begin errs++; $display("FAIL byte_unsigned: got %h cyc=%0d required 000000aa cyc=2", r_rd, r_cyc); end
        access(1'b1, 32'h403, 32'h15A, 4'b0001, 0);
        vecs++;
        if (r_strb !== 4'b1000 || r_mwd !== 32'h5A000000) begin errs++; $display("FAIL byte_lane3: got strb=%b wdata=%h required 1000 5a000000", r_strb, r_mwd); end
        access(1'b0, 32'h403, '0, 4'b1001, 0);
        vecs++;
        if (r_rd !== 32'h0000005A || hit_count !== 32'd6) begin errs++; $display("FAIL byte_lane3_load: got %h hits=%0d required 0000005a hits=6", r_rd, hit_count); end
    endtask

    task automatic test_half;
        access(1'b1, 32'h102, 32'h2AAAA, 4'b0011, 0);
        vecs++;
        if (r_strb !== 4'b1100 || r_mwd !== 32'hAAAA0000 || r_maddr !== 32'h100) begin errs++; $display("FAIL half_store: got strb=%b wdata=%h @%h required 1100 aaaa0000 @00000100", r_strb, r_mwd, r_maddr); end
        vecs++;
        if (miss_count !== 32'd3) begin errs++; $display("FAIL half_store_miss: got %0d required 3", miss_count); end
        access(1'b0, 32'h102, '0, 4'b1011, 2);
        vecs++;
        if (r_rd !== 32'hFFFFAAAA || r_sawrd !== 1'b1) begin errs++; $display("FAIL half_signed: got %h memread=%b required ffffaaaa memread=1", r_rd, r_sawrd); end
        access(1'b0, 32'h102, '0, 4'b0011, 0);
        vecs++;
        if (r_rd !== 32'h0000AAAA || r_cyc !== 2) begin errs++; $display("FAIL half_unsigned: got %h cyc=%0d required 0000aaaa cyc=2", r_rd, r_cyc); end
        access(1'b0, 32'h103, '0, 4'b0011, 0);
        vecs++;
        if (r_rd !== 32'h0000AAAA || hit_count !== 32'd8) begin errs++; $display("FAIL half_addr0_ignored: got %h hits=%0d required 0000aaaa hits=8", r_rd, hit_count); end
    endtask

    task automatic test_write_miss;
        access(1'b1, 32'h200, 32'h12345678, 4'b0111, 1);
        vecs++;
        if ({r_sawrd, r_sawwr, r_strb} !== 6'b01_1111 || r_mwd !== 32'h12345678 || r_maddr !== 32'h200) begin
            errs++; $display("FAIL wmiss_bus: got rd=%b wr=%b strb=%b wdata=%h @%h required 0 1 1111 12345678 @00000200", r_sawrd, r_sawwr, r_strb, r_mwd, r_maddr);
        end
        vecs++;
        if (miss_count !== 32'd5) begin errs++; $display("FAIL wmiss_count: got %0d required 5", miss_count); end
        access(1'b0, 32'h203, '0, 4'b0111, 1);
        vecs++;
        if (r_sawrd !== 1'b1 || r_maddr !== 32'h200 || r_rd !== 32'h12345678) begin errs++; $display("FAIL no_allocate: got memread=%b @%h data=%h required 1 @00000200 12345678", r_sawrd, r_maddr, r_rd); end
        vecs++;
        if (miss_count !== 32'd6) begin errs++; $display("FAIL wmiss_then_load_count: got %0d required 6", miss_count); end
    endtask

    task automatic test_lru;
        logic [31:0] la [6] = '{32'h000, 32'h040, 32'h000, 32'h080, 32'h000, 32'h040};
        logic        lm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ld [6] = '{32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'h33333333, 32'h11111111, 32'hAAAAAAAA};
        mem[0] = 32'h11111111;
        mem[32'h80 >> 2] = 32'h33333333;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            access(1'b0, la[i], '0, 4'b0111, 1);
            vecs++;
            if (r_sawrd !== lm[i] || r_rd !== ld[i]) begin errs++; $display("FAIL lru_step%0d @%h: got miss=%b data=%h required miss=%b data=%h", i, la[i], r_sawrd, r_rd, lm[i], ld[i]); end
        end
        vecs++;
        if (miss_count !== 32'd4 || hit_count !== 32'd2) begin errs++; $display("FAIL lru_counts: got miss=%0d hit=%0d required 4 2", miss_count, hit_count); end
    endtask

    task automatic test_reset_in_fill;
        bit seen;
        seen = 1'b0;
        mem[32'h300 >> 2] = 32'hC0FFEE00;
        @(negedge clk);
        addr = 32'h300; sign_mask = 4'b0111; memread = 1'b1;
        @(posedge clk);
        #1 memread = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        vecs++;
        if (!seen) begin errs++; $display("FAIL rst_fill_reach: got mem_read=0 required 1 before reset"); end
        reset = 1'b1;
        #1;
        vecs++;
        if ({mem_read, clk_stall, mem_addr} !== '0) begin errs++; $display("FAIL rst_fill_drop: got mr=%b stall=%b addr=%h required 0", mem_read, clk_stall, mem_addr); end
        vecs++;
        if ({hit_count, miss_count, led} !== '0) begin errs++; $display("FAIL rst_fill_counters: got hit=%0d miss=%0d led=%h required 0", hit_count, miss_count, led); end
        @(negedge clk) reset = 1'b0;
        access(1'b0, 32'h300, '0, 4'b0111, 0);
        vecs++;
        if (r_sawrd !== 1'b1 || r_rd !== 32'hC0FFEE00 || miss_count !== 32'd1) begin errs++; $display("FAIL rst_fill_reload: got memread=%b data=%h miss=%0d required 1 c0ffee00 1", r_sawrd, r_rd, miss_count); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_cold_read();
        test_byte();
        test_half();
        test_write_miss();
        test_lru();
        test_reset_in_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
